// File: rtl/sw_rr_scheduler16_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sw_sched_pkg
// Description : Shared types and constants for the 16-switch round-robin
//               scheduler (requester count, index width, FSM state type,
//               one-hot helper).
// Revision    : 1.0 - initial release
// ============================================================================
package sw_sched_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input idx_t i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_rr_scheduler16_if.sv
`default_nettype none
// ============================================================================
// Interface   : sw_rr_scheduler16_if
// Description : Switch-request / grant bundle of the scheduler.
//               sw    : raw switch requests (async to clk)
//               LED   : binary index of the current grantee, 0 when idle
//               grant : one-hot grant, all zero when idle
//               valid : high while a grant is active
//               master drives sw, slave (the scheduler) drives the rest.
// Revision    : 1.0 - initial release
// ============================================================================
interface sw_rr_scheduler16_if;
    logic [15:0] sw;
    logic [3:0]  LED;
    logic [15:0] grant;
    logic        valid;

    modport master (output sw, input LED, input grant, input valid);
    modport slave  (input sw, output LED, output grant, output valid);
endinterface
`default_nettype wire

// File: rtl/sw_rr_scheduler16_rr_pick16.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick16
// Description : Combinational round-robin picker. Finds the first set bit of
//               (req & mask) starting at index ptr and wrapping modulo 16.
//               Ports: req  - request vector
//                      ptr  - search start index
//                      mask - requesters allowed to win (1 = eligible)
//                      found- at least one eligible requester
//                      idx  - winning index (0 when none found)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick16
    import sw_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  idx_t             ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output idx_t             idx
);

    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] rot;
    idx_t             off;
    idx_t             src;

    always_comb begin
        masked = req & mask;
        // Rotate so that position 0 of rot corresponds to req[ptr].
        rot = '0;
        src = '0;
        for (int i = 0; i < N_REQ; i++) begin
            src    = idx_t'(i) + ptr;
            rot[i] = masked[src];
        end
        found = |rot;
        // Lowest set bit of the rotated vector wins.
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = idx_t'(i);
            end
        end
        // Un-rotate; 4-bit addition wraps modulo 16.
        idx = found ? idx_t'(off + ptr) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/sw_rr_scheduler16.sv
`default_nettype none
// ============================================================================
// Module      : sw_rr_scheduler16
// Description : Round-robin time-slice scheduler for 16 switches. Grants one
//               requester at a time for HOLD_CYCLES clocks and reports the
//               winner as a binary index (LED) and one-hot vector (grant).
//               Ports: clk   - system clock
//                      rst_n - asynchronous active-low reset
//                      bus   - slave side of sw_rr_scheduler16_if
// Revision    : 1.0 - initial release
// ============================================================================
module sw_rr_scheduler16
    import sw_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sw_rr_scheduler16_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_reload = CNT_W'(HOLD_CYCLES - 1);

    logic [N_REQ-1:0] sync1_q, sync1_d;
    logic [N_REQ-1:0] sync2_q, sync2_d;
    state_t           state_q, state_d;
    idx_t             cur_q, cur_d;
    idx_t             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    idx_t             led_q, led_d;
    logic             valid_q, valid_d;

    logic [N_REQ-1:0] req;
    idx_t             pick_ptr;
    logic [N_REQ-1:0] pick_mask;
    logic             pick_found;
    idx_t             pick_idx;

    assign req = sync2_q;

    // While granting, the search always starts just past cur and excludes
    // cur, so "found" means another requester is waiting.
    always_comb begin
        if (state_q == GRANT) begin
            pick_ptr  = idx_t'(cur_q + idx_t'(1));
            pick_mask = ~onehot(cur_q);
        end else begin
            pick_ptr  = ptr_q;
            pick_mask = '1;
        end
    end

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        sync1_d = bus.sw;
        sync2_d = sync1_q;
        state_d = state_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    cur_d   = pick_idx;
                    cnt_d   = c_reload;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Release is checked first so release coinciding with
                // expiry never re-grants the departing requester.
                if (!req[cur_q]) begin
                    ptr_d = pick_ptr;
                    if (pick_found) begin
                        cur_d = pick_idx;
                        cnt_d = c_reload;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == '0) begin
                    ptr_d = pick_ptr;
                    cnt_d = c_reload;
                    if (pick_found) begin
                        cur_d = pick_idx;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == GRANT);
        grant_d = valid_d ? onehot(cur_d) : '0;
        led_d   = valid_d ? cur_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= IDLE;
            cur_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            led_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            valid_q <= valid_d;
        end
    end

    assign bus.LED   = led_q;
    assign bus.grant = grant_q;
    assign bus.valid = valid_q;

endmodule
`default_nettype wire

// File: doc/sw_rr_scheduler16.md
# sw_rr_scheduler16

Round-robin time-slice scheduler for the 16 board switches. Each asserted switch is a requester. The block grants one requester at a time for a fixed slice and reports the winner both as a 4-bit binary index on the LEDs and as a one-hot grant vector. It sits between the raw Basys 3 switch inputs and any shared downstream resource (display, counter, UART channel) that may serve only one switch at a time.

## Interface
- HOLD_CYCLES, 100_000_000: slice length in clk cycles (1 s at 100 MHz); legal range 1 to 2^CNT_W.
- CNT_W, 27: slice counter width.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- sw  in  16  raw switch requests, asynchronous to clk.
- LED  out  4  binary index of the current grantee; 0 when idle.
- grant  out  16  one-hot grant; all zero when idle.
- valid  out  1  high while a grant is active.

## Operation
- sw passes through a 2-flop synchronizer to produce req[15:0]. All arbitration uses req only.
- ptr[3:0] is the search start. The pick is the first set bit of req at index ptr, ptr+1, … 15, 0, … ptr-1, with modulo-16 wrap.
- FSM states: IDLE, GRANT.
  - IDLE: outputs zero. If req != 0: cur <= pick, cnt <= HOLD_CYCLES-1, go to GRANT.
  - GRANT, normal: cnt decrements each cycle while req[cur]=1.
  - GRANT, expiry (cnt==0 and req[cur]=1): ptr <= cur+1 mod 16, then re-pick from the new ptr.
    - A requester other than cur exists: grant it, reload cnt.
    - cur is the only requester: re-grant cur with cnt reloaded. No idle gap.
  - GRANT, early release (req[cur]=0, checked before expiry): ptr <= cur+1. If another requester exists, grant it. Otherwise go to IDLE.
- grant = one-hot(cur), LED = cur and valid = 1 in GRANT. All three are registered and change together.
- No requester is granted twice while another requester is waiting. The worst-case wait is 15 × HOLD_CYCLES.
- New requests arriving mid-slice do not pre-empt the current grant.

## Timing
- Reset (async, rst_n=0): state=IDLE, LED=0, grant=0, valid=0, ptr=0, cnt=0, synchronizer flops=0. Outputs clear immediately on assertion, not at the next edge.
- Latency: a sw bit rising while idle is sampled at edge N. req rises at edge N+1 and valid/grant/LED rise at edge N+2.
- Under contention a slice lasts exactly HOLD_CYCLES cycles, measured from the first cycle of valid/grant to the grant handover.
- Handover is back-to-back. grant moves from one-hot A to one-hot B in a single edge, with no all-zero cycle and valid held high.
- Early release: cur's sw falls at edge N, req[cur] falls at edge N+1, and the new grant or IDLE appears at edge N+2.
- Release and expiry in the same cycle are treated as release.
- Reset asserted mid-slice aborts the slice. After release of reset, arbitration restarts from ptr=0.
- HOLD_CYCLES=1: every contended grant lasts one cycle and rotates each edge.

## Structure
- Package sw_sched_pkg holds:
  - N_REQ=16, IDX_W=4.
  - typedef state_t {IDLE, GRANT}.
  - typedef idx_t logic[IDX_W-1:0].
- Sub-module rr_pick16 is purely combinational.
  - Inputs: req[15:0], ptr[3:0], plus a mask input excluding cur.
  - Outputs: found and idx[3:0].
  - Implement as rotate, priority-encode, un-rotate.
- Top level holds the synchronizer, FSM, counter and output registers.

## Test plan
All scenarios use HOLD_CYCLES=4.
- Single request: reset, then sw=16'h0020. Valid rises 2 edges after sampling with LED=5 and grant=16'h0020. It stays granted indefinitely, re-granted every 4 cycles with no valid drop.
- Contention rotation: sw=16'h8101. The grant order is 0, 8, 15, 0 …, each slice exactly 4 cycles, with LED values 0, 8, 15, 0.
- Wrap-around: arrive at cur=15 with sw=16'h8002. The next grant is index 1; ptr wraps to 0 and the search finds 1.
- Early release: grant on index 3 with sw=16'h0018. Dropping sw[3] after 1 cycle hands over to index 4 two edges later. Dropping all sw instead gives valid=0, grant=0, LED=0.
- Simultaneous release and expiry: drop sw[cur] so req falls in the cnt==0 cycle. The result is the same as early release, and cur is never re-granted.
- Reset mid-slice: pulse rst_n low during a grant on index 9. Outputs are zero asynchronously. With sw=16'h0201 held, the first grant after reset is index 0 (ptr=0).
